// File: rtl/alu_fe_pkg.sv
// Shared definitions for the ALU command front end: opcodes, the command
// marker, the FSM state encoding and the status-byte layout.
package alu_fe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] CMD_MARKER = 4'hA;

  // Bit positions inside the status byte {6'b0, div0, carry}
  localparam int STAT_CARRY_BIT = 0;
  localparam int STAT_DIV0_BIT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_TX    = 3'd5
  } fe_state_t;

  // A command byte is accepted only with the marker nibble and zero reserved bits
  function automatic logic is_valid_cmd(input logic [7:0] b);
    return (b[7:4] == CMD_MARKER) && (b[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_cmd_frontend_if.sv
// Bundle of the byte receiver, ALU and byte transmitter signals seen by the
// command front end.
//
// Handshake rule for both byte streams: a byte moves on a rising clock edge
// where valid && ready are both high; the source holds data and valid stable
// until that edge, and ready never depends combinationally on valid.
interface alu_cmd_frontend_if #(parameter int Width = 16);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [1:0]       alu_fun;
  logic             arith_enable;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic [Width-1:0] arith_out;
  logic             carry_out;
  logic             arith_flag;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             cmd_err;

  // Front end side
  modport master (
    input  rx_data, rx_valid, arith_out, carry_out, arith_flag, tx_ready,
    output rx_ready, alu_fun, arith_enable, A, B, tx_data, tx_valid, cmd_err
  );

  // Byte source / ALU / byte sink side
  modport slave (
    output rx_data, rx_valid, arith_out, carry_out, arith_flag, tx_ready,
    input  rx_ready, alu_fun, arith_enable, A, B, tx_data, tx_valid, cmd_err
  );
endinterface

// File: rtl/alu_result_serializer.sv
// Holds the response (result bytes then status byte) and shifts it out one
// byte per tx handshake. A load pulse starts a response; done marks the
// handshake edge of the status byte.
module alu_result_serializer
  import alu_fe_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_result,
  input  logic             i_carry,
  input  logic             i_div0,
  input  logic             i_tx_ready,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  output logic             o_done
);

  localparam int NB = Width / 8;
  localparam int IW = $clog2(NB + 1);

  logic [Width+7:0] r_shift;
  logic [IW-1:0]    r_idx;
  logic             r_valid;
  logic [7:0]       w_status;
  logic             w_xfer;
  logic             w_last;

  // Assemble the status byte from its flag bits
  always_comb begin
    w_status                 = '0;
    w_status[STAT_CARRY_BIT] = i_carry;
    w_status[STAT_DIV0_BIT]  = i_div0;
  end

  assign w_xfer = r_valid && i_tx_ready;
  assign w_last = (r_idx == IW'(NB));

  // Load the response, then shift a byte out on each accepted handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= {w_status, i_result};
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= r_shift >> 8;
      if (w_last) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign o_tx_data  = r_shift[7:0];
  assign o_tx_valid = r_valid;
  assign o_done     = w_xfer && w_last;

endmodule

// File: rtl/alu_cmd_frontend.sv
// Command front end for the arithmetic unit: parses command frames from the
// byte receiver, fires the ALU once, captures its result and hands the
// response to the serializer. Divide-by-zero is answered locally.
module alu_cmd_frontend
  import alu_fe_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic                CLK,
  input  logic                RST,
  alu_cmd_frontend_if.master  bus,
  output fe_state_t           dbg_state,
  output logic                dbg_flag_err
);

  localparam int NB = Width / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  fe_state_t        r_state, w_next;
  logic [1:0]       r_fun;
  logic [Width-1:0] r_a, r_b, w_b_next;
  logic [CW-1:0]    r_cnt;
  logic             r_cmd_err;
  logic             w_rx_ready, w_rx_fire, w_last_byte, w_div0;
  logic             w_load, w_ld_div0, w_ld_carry, w_done;
  logic [Width-1:0] w_ld_result;

  assign w_rx_ready  = (r_state == ST_IDLE) || (r_state == ST_GET_A) || (r_state == ST_GET_B);
  assign w_rx_fire   = bus.rx_valid && w_rx_ready;
  assign w_last_byte = (r_cnt == CW'(NB - 1));

  // B as it will be once the incoming byte lands, for the div-by-zero test
  always_comb begin
    w_b_next                = r_b;
    w_b_next[r_cnt*8 +: 8]  = bus.rx_data;
  end

  assign w_div0 = (r_fun == OP_DIV) && (w_b_next == '0);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and serializer load control
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_ld_result = '0;
    w_ld_carry  = 1'b0;
    w_ld_div0   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_rx_fire && is_valid_cmd(bus.rx_data)) w_next = ST_GET_A;
      ST_GET_A: if (w_rx_fire && w_last_byte) w_next = ST_GET_B;
      ST_GET_B: begin
        if (w_rx_fire && w_last_byte) begin
          if (w_div0) begin
            w_next    = ST_TX;
            w_load    = 1'b1;
            w_ld_div0 = 1'b1;
          end else begin
            w_next = ST_EXEC;
          end
        end
      end
      ST_EXEC:  w_next = ST_WAIT;
      ST_WAIT: begin
        w_next      = ST_TX;
        w_load      = 1'b1;
        w_ld_result = bus.arith_out;
        w_ld_carry  = bus.carry_out;
      end
      ST_TX:    if (w_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Opcode latch, operand assembly and invalid-command pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fun     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_rx_fire) begin
        case (r_state)
          ST_IDLE: begin
            if (is_valid_cmd(bus.rx_data)) begin
              r_fun <= bus.rx_data[1:0];
              r_cnt <= '0;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          ST_GET_A: begin
            r_a[r_cnt*8 +: 8] <= bus.rx_data;
            r_cnt <= w_last_byte ? '0 : r_cnt + CW'(1);
          end
          ST_GET_B: begin
            r_b   <= w_b_next;
            r_cnt <= w_last_byte ? '0 : r_cnt + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  alu_result_serializer #(.Width(Width)) u_ser (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_result   (w_ld_result),
    .i_carry    (w_ld_carry),
    .i_div0     (w_ld_div0),
    .i_tx_ready (bus.tx_ready),
    .o_tx_data  (bus.tx_data),
    .o_tx_valid (bus.tx_valid),
    .o_done     (w_done)
  );

  assign bus.rx_ready     = w_rx_ready;
  assign bus.alu_fun      = r_fun;
  assign bus.A            = r_a;
  assign bus.B            = r_b;
  assign bus.arith_enable = (r_state == ST_EXEC);
  assign bus.cmd_err      = r_cmd_err;

  assign dbg_state    = r_state;
  assign dbg_flag_err = (r_state == ST_WAIT) && !bus.arith_flag;

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Directed bench for alu_cmd_frontend with a registered ALU model and a
// byte scoreboard for the responses.
module tb_alu_cmd_frontend;
  import alu_fe_pkg::*;

  localparam int W  = 16;
  localparam int NB = W / 8;

  logic      CLK;
  logic      RST;
  fe_state_t dbg_state;
  logic      dbg_flag_err;

  alu_cmd_frontend_if #(.Width(W)) bus ();

  alu_cmd_frontend #(.Width(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_flag_err (dbg_flag_err)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- registered ALU model ----------------
  function automatic logic [W:0] alu_calc(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (f)
      OP_ADD: alu_calc = {1'b0, a} + {1'b0, b};
      OP_SUB: alu_calc = {1'b0, a} - {1'b0, b};
      OP_MUL: begin
        p = a * b;
        alu_calc = p[W:0];
      end
      default: alu_calc = (b == '0) ? '0 : {1'b0, a / b};
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.arith_out  <= '0;
      bus.carry_out  <= 1'b0;
      bus.arith_flag <= 1'b0;
    end else begin
      bus.arith_flag <= bus.arith_enable;
      if (bus.arith_enable)
        {bus.carry_out, bus.arith_out} <= alu_calc(bus.alu_fun, bus.A, bus.B);
    end
  end

  // Monitor: fire-pulse count and ALU flag at the capture edge
  always @(negedge CLK) begin
    if (bus.arith_enable) en_cnt++;
    if (!RST && dbg_state == ST_WAIT) chk("alu_flag_capture", {31'b0, bus.arith_flag}, 32'd1);
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("rx_ready_wait", {31'b0, bus.rx_ready}, 32'd1);
    @(negedge CLK);
    bus.rx_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int stall_len);
    int n;
    for (int i = 0; i <= NB; i++) begin
      n = 0;
      while (!bus.tx_valid && n < 100) begin
        @(negedge CLK);
        n++;
      end
      if (n >= 100) chk({tag, "_tx_valid_wait"}, {31'b0, bus.tx_valid}, 32'd1);
      if (i == 1 && stall_len > 0) begin
        bus.tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge CLK);
          chk({tag, "_stall_data"}, {24'b0, bus.tx_data}, {24'b0, exp_q[0]});
          chk({tag, "_stall_valid"}, {31'b0, bus.tx_valid}, 32'd1);
        end
        chk({tag, "_rx_ready_busy"}, {31'b0, bus.rx_ready}, 32'd0);
      end
      bus.tx_ready = 1'b1;
      chk({tag, "_resp_byte"}, {24'b0, bus.tx_data}, {24'b0, exp_q.pop_front()});
      @(negedge CLK);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic do_frame(input string tag,
                          input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                          input bit div0, input int stall_len);
    int en0;
    en0 = en_cnt;
    send_byte(c);
    send_byte(a0);
    send_byte(a1);
    send_byte(b0);
    send_byte(b1);
    if (div0) begin
      chk({tag, "_txv_after_e0"}, {31'b0, bus.tx_valid}, 32'd1);
      chk({tag, "_en_after_e0"}, {31'b0, bus.arith_enable}, 32'd0);
    end else begin
      chk({tag, "_en_after_e0"}, {31'b0, bus.arith_enable}, 32'd1);
      chk({tag, "_txv_after_e0"}, {31'b0, bus.tx_valid}, 32'd0);
      @(negedge CLK);
      chk({tag, "_en_after_e1"}, {31'b0, bus.arith_enable}, 32'd0);
      chk({tag, "_txv_after_e1"}, {31'b0, bus.tx_valid}, 32'd0);
      @(negedge CLK);
      chk({tag, "_txv_after_e2"}, {31'b0, bus.tx_valid}, 32'd1);
    end
    exp_q.push_back(r0);
    exp_q.push_back(r1);
    exp_q.push_back(r2);
    collect(tag, stall_len);
    chk({tag, "_en_pulses"}, en_cnt - en0, div0 ? 32'd0 : 32'd1);
    chk({tag, "_idle_rx_ready"}, {31'b0, bus.rx_ready}, 32'd1);
    chk({tag, "_idle_txv"}, {31'b0, bus.tx_valid}, 32'd0);
    chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, bus.rx_ready}, 32'd1);
    chk({tag, "_A"}, {16'b0, bus.A}, 32'd0);
    chk({tag, "_B"}, {16'b0, bus.B}, 32'd0);
    chk({tag, "_alu_fun"}, {30'b0, bus.alu_fun}, 32'd0);
    chk({tag, "_arith_en"}, {31'b0, bus.arith_enable}, 32'd0);
    chk({tag, "_tx_data"}, {24'b0, bus.tx_data}, 32'd0);
    chk({tag, "_tx_valid"}, {31'b0, bus.tx_valid}, 32'd0);
    chk({tag, "_cmd_err"}, {31'b0, bus.cmd_err}, 32'd0);
    chk({tag, "_state"}, {29'b0, dbg_state}, {29'b0, ST_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b0;
    @(negedge CLK);

    // add 0x1234 + 0x0F0F = 0x2143
    do_frame("add", 8'hA0, 8'h34, 8'h12, 8'h0F, 8'h0F, 8'h43, 8'h21, 8'h00, 1'b0, 0);
    chk("add_A_hold", {16'b0, bus.A}, 32'h1234);
    chk("add_B_hold", {16'b0, bus.B}, 32'h0F0F);

    // sub 1 - 2 borrows: 0xFFFF, carry 1
    do_frame("sub", 8'hA1, 8'h01, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h01, 1'b0, 0);

    // mul 0x100 * 0x100 = 0x10000: truncated to 0, carry 1
    do_frame("mul", 8'hA2, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 0);

    // divide by zero answered locally
    do_frame("div0", 8'hA3, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1'b1, 0);
    chk("div0_fun_hold", {30'b0, bus.alu_fun}, 32'd3);

    // ordinary divide 100 / 7 = 14
    do_frame("div", 8'hA3, 8'h64, 8'h00, 8'h07, 8'h00, 8'h0E, 8'h00, 8'h00, 1'b0, 0);

    // invalid command byte, then an add with a 5-cycle sink stall
    send_byte(8'hB5);
    chk("bad_cmd_err_pulse", {31'b0, bus.cmd_err}, 32'd1);
    chk("bad_cmd_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    @(negedge CLK);
    chk("bad_cmd_err_clear", {31'b0, bus.cmd_err}, 32'd0);
    do_frame("add_stall", 8'hA0, 8'h34, 8'h12, 8'h0F, 8'h0F, 8'h43, 8'h21, 8'h00, 1'b0, 5);
    chk("add_stall_no_err", {31'b0, bus.cmd_err}, 32'd0);

    // reset in the middle of a frame
    send_byte(8'hA0);
    send_byte(8'h34);
    chk("midrst_state_before", {29'b0, dbg_state}, {29'b0, ST_GET_A});
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals("midrst");
    RST = 1'b0;
    @(negedge CLK);
    do_frame("after_rst", 8'hA0, 8'h34, 8'h12, 8'h0F, 8'h0F, 8'h43, 8'h21, 8'h00, 1'b0, 0);

    // back-to-back frames with no idle gap
    do_frame("b2b_1", 8'hA0, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 0);
    do_frame("b2b_2", 8'hA1, 8'h05, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 8'h00, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
